// File: rtl/la_pkg.sv
// Shared types and trigger-mode encodings for the logic-analyser capture path.
package la_pkg;

    localparam logic [2:0] TRIG_IMM   = 3'd0;
    localparam logic [2:0] TRIG_LEVEL = 3'd1;
    localparam logic [2:0] TRIG_RISE  = 3'd2;
    localparam logic [2:0] TRIG_FALL  = 3'd3;
    localparam logic [2:0] TRIG_EDGE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } la_state_e;

endpackage

// File: rtl/la_trig_detect.sv
// Masked trigger evaluation; holds the previous-sample register for edge modes.
import la_pkg::*;

module la_trig_detect #(
    parameter int CH_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            tick_i,
    input  logic [CH_W-1:0] sample_i,
    input  logic [CH_W-1:0] mask_i,
    input  logic [CH_W-1:0] value_i,
    input  logic [2:0]      mode_i,
    output logic            hit_o
);

    logic [CH_W-1:0] prev_q;
    logic            prev_vld_q;
    logic [CH_W-1:0] rise;
    logic [CH_W-1:0] fall;
    logic            level;

    // The first sample of a capture has no predecessor, so no edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clr_i) begin
            prev_vld_q <= 1'b0;
        end else if (tick_i) begin
            prev_q     <= sample_i;
            prev_vld_q <= 1'b1;
        end
    end

    always_comb begin
        rise  = '0;
        fall  = '0;
        if (prev_vld_q) begin
            rise = ~prev_q & sample_i & mask_i;
            fall = prev_q & ~sample_i & mask_i;
        end
        level = (|mask_i) &&
                (((sample_i ^ value_i) & mask_i) == '0);
    end

    always_comb begin
        hit_o = 1'b1;
        case (mode_i)
            TRIG_LEVEL: hit_o = level;
            TRIG_RISE:  hit_o = |rise;
            TRIG_FALL:  hit_o = |fall;
            TRIG_EDGE:  hit_o = |(rise | fall);
            default:    hit_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: divider, circular write pointer and FSM.
// Optional LA_FORCE_TRIG_EN adds a force_trig input usable in WAIT_TRIG.
import la_pkg::*;

module la_capture_ctrl #(
    parameter int CH_W   = 8,
    parameter int ADDR_W = 17,
    parameter int DIV_W  = 16
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [DIV_W-1:0]  div_sel,
    input  logic [2:0]        trig_mode,
    input  logic [CH_W-1:0]   trig_mask,
    input  logic [CH_W-1:0]   trig_value,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic [CH_W-1:0]   data_in,
`ifdef LA_FORCE_TRIG_EN
    input  logic              force_trig,
`endif
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CH_W-1:0]   wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] start_addr
);

    la_state_e         state_q, state_d;
    logic [CH_W-1:0]   sync1_q, sync2_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  div_q;
    logic [2:0]        mode_q;
    logic [CH_W-1:0]   mask_q, value_q;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              trig_q, trig_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CH_W-1:0]   wr_data_q, wr_data_d;

    logic              busy_s;
    logic              arm_go;
    logic              tick;
    logic              cap_tick;
    logic              det_hit;
    logic              force_hit;
    logic              trig_fire;
    logic [ADDR_W:0]   post_cnt;

    assign busy_s = (state_q == PRE) ||
                    (state_q == WAIT_TRIG) ||
                    (state_q == POST);
    assign arm_go = arm && !abort &&
                    ((state_q == IDLE) || (state_q == DONE));
    assign tick     = (div_cnt_q == div_q);
    assign cap_tick = tick && busy_s;

    // Window length after the trigger, trigger sample included.
    assign post_cnt = {1'b1, {ADDR_W{1'b0}}} - {1'b0, pre_q};

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            mode_q  <= TRIG_IMM;
            mask_q  <= '0;
            value_q <= '0;
            pre_q   <= '0;
        end else if (arm_go) begin
            div_q   <= div_sel;
            mode_q  <= trig_mode;
            mask_q  <= trig_mask;
            value_q <= trig_value;
            pre_q   <= pretrig_len;
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (arm_go || tick) begin
            div_cnt_d = '0;
        end
    end

    la_trig_detect #(
        .CH_W(CH_W)
    ) u_trig (
        .clk_i   (clk_50M),
        .rst_ni  (rst_n),
        .clr_i   (arm_go),
        .tick_i  (cap_tick),
        .sample_i(sync2_q),
        .mask_i  (mask_q),
        .value_i (value_q),
        .mode_i  (mode_q),
        .hit_o   (det_hit)
    );

`ifdef LA_FORCE_TRIG_EN
    logic force_pend_q, force_pend_d;
    logic force_now;

    assign force_now = force_trig && (state_q == WAIT_TRIG);
    assign force_hit = force_pend_q || force_now;

    always_comb begin
        force_pend_d = 1'b0;
        if ((state_q == WAIT_TRIG) && !abort) begin
            force_pend_d = force_hit && !cap_tick;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            force_pend_q <= 1'b0;
        end else begin
            force_pend_q <= force_pend_d;
        end
    end
`else
    assign force_hit = 1'b0;
`endif

    assign trig_fire = det_hit || force_hit;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        trig_d      = trig_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (cap_tick) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sync2_q;
            ptr_d     = ptr_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (arm_go) begin
                    ptr_d   = '0;
                    cnt_d   = '0;
                    trig_d  = 1'b0;
                    state_d = (pretrig_len == '0) ? WAIT_TRIG : PRE;
                end
            end
            PRE: begin
                if (cap_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == {1'b0, pre_q}) begin
                        cnt_d   = '0;
                        state_d = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                if (cap_tick && trig_fire) begin
                    trig_addr_d = ptr_q;
                    trig_d      = 1'b1;
                    cnt_d       = {{ADDR_W{1'b0}}, 1'b1};
                    state_d     = (post_cnt == {{ADDR_W{1'b0}}, 1'b1})
                                  ? DONE : POST;
                end
            end
            POST: begin
                if (cap_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == post_cnt) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            trig_d  = 1'b0;
            wr_en_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            trig_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            trig_q      <= trig_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_s;
    assign triggered  = trig_q;
    assign done       = (state_q == DONE);
    assign start_addr = done ? (trig_addr_q - pre_q) : '0;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with DEPTH=16.
// Define LA_FORCE_TRIG_EN to also exercise force_trig.
module tb_la_capture_ctrl;

    logic       clk_50M = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [15:0] div_sel = '0;
    logic [2:0] trig_mode = '0;
    logic [7:0] trig_mask = '0;
    logic [7:0] trig_value = '0;
    logic [3:0] pretrig_len = '0;
    logic [7:0] data_in = '0;
    logic       force_trig = 1'b0;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       busy;
    logic       triggered;
    logic       done;
    logic [3:0] start_addr;

    la_capture_ctrl #(
        .CH_W(8),
        .ADDR_W(4),
        .DIV_W(16)
    ) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .arm        (arm),
        .abort      (abort),
        .div_sel    (div_sel),
        .trig_mode  (trig_mode),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .pretrig_len(pretrig_len),
        .data_in    (data_in),
`ifdef LA_FORCE_TRIG_EN
        .force_trig (force_trig),
`endif
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .start_addr (start_addr)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int         div;
        logic [2:0] mode;
        logic [7:0] mask;
        logic [7:0] value;
        int         pre;
        logic [7:0] data;
        bit         tog;
        int         chg_at;
        logic [7:0] chg_data;
        bit         fires;
        int         exp_wr;
        int         exp_start;
        int         exp_hit;
    } vec_t;

    vec_t vecs[11];

    int checks = 0;
    int errors = 0;
    int nwr, seq_err, gap_err, first_addr, hit_addr;
    logic [7:0] watch;

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic configure(input int div, input logic [2:0] mode,
                             input logic [7:0] mask, input logic [7:0] val,
                             input int pre, input logic [7:0] data);
        div_sel     = 16'(div);
        trig_mode   = mode;
        trig_mask   = mask;
        trig_value  = val;
        pretrig_len = 4'(pre);
        data_in     = data;
        repeat (3) step();
    endtask

    task automatic run(input int maxclk, input int per, input bit midarm,
                       input bit tog, input int chg_at,
                       input logic [7:0] chg_data);
        int gap;
        int prev;
        nwr = 0;
        seq_err = 0;
        gap_err = 0;
        first_addr = -1;
        hit_addr = -1;
        gap = 0;
        prev = -1;
        for (int c = 0; c < maxclk; c++) begin
            arm = midarm && (c == maxclk / 2);
            if (tog) data_in = ~data_in;
            step();
            gap++;
            if (wr_en) begin
                if (prev >= 0 && wr_addr != 4'(prev + 1)) seq_err++;
                if (nwr > 0 && gap != per) gap_err++;
                if (first_addr < 0) first_addr = int'(wr_addr);
                if (hit_addr < 0 && wr_data == watch)
                    hit_addr = int'(wr_addr);
                if (chg_at >= 0 && int'(wr_addr) == chg_at)
                    data_in = chg_data;
                prev = int'(wr_addr);
                nwr++;
                gap = 0;
            end
            if (done) break;
        end
        arm = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{0, 3'd0, 8'h00, 8'h00, 0, 8'h5A, 0, -1, 8'h00, 1, 16, 0, -1};
        vecs[1]  = '{3, 3'd0, 8'h00, 8'h00, 0, 8'h3C, 0, -1, 8'h00, 1, 16, 0, -1};
        vecs[2]  = '{0, 3'd5, 8'h00, 8'h00, 3, 8'h11, 0, -1, 8'h00, 1, 16, 0, -1};
        vecs[3]  = '{1, 3'd1, 8'hF0, 8'hA5, 2, 8'hA0, 0, -1, 8'h00, 1, 16, 0, -1};
        vecs[4]  = '{3, 3'd2, 8'h01, 8'h00, 4, 8'h00, 0, 9, 8'h01, 1, 22, 6, 10};
        vecs[5]  = '{0, 3'd7, 8'h00, 8'h00, 15, 8'h00, 0, -1, 8'h00, 1, 16, 0, -1};
        vecs[6]  = '{3, 3'd3, 8'h80, 8'h00, 6, 8'h80, 0, 8, 8'h00, 1, 19, 3, 9};
        vecs[7]  = '{2, 3'd1, 8'hF0, 8'hA5, 0, 8'hB5, 0, -1, 8'h00, 0, 0, 0, -1};
        vecs[8]  = '{0, 3'd2, 8'h00, 8'h00, 0, 8'h55, 1, -1, 8'h00, 0, 0, 0, -1};
        vecs[9]  = '{0, 3'd1, 8'h00, 8'h00, 0, 8'h00, 0, -1, 8'h00, 0, 0, 0, -1};
        vecs[10] = '{0, 3'd2, 8'h01, 8'h00, 0, 8'h01, 0, -1, 8'h00, 0, 0, 0, -1};

        repeat (2) step();
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();
        check("rst_done", int'(done), 0);
        check("rst_trig", int'(triggered), 0);
        check("rst_start", int'(start_addr), 0);
        check("rst_addr", int'(wr_addr), 0);

        for (int i = 0; i < 11; i++) begin
            configure(vecs[i].div, vecs[i].mode, vecs[i].mask,
                      vecs[i].value, vecs[i].pre, vecs[i].data);
            watch = vecs[i].chg_data;
            do_arm();
            if (vecs[i].fires) begin
                run((vecs[i].exp_wr + 4) * (vecs[i].div + 1) + 10,
                    vecs[i].div + 1, 0, vecs[i].tog,
                    vecs[i].chg_at, vecs[i].chg_data);
                check($sformatf("v%0d_done", i), int'(done), 1);
                check($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_wr);
                check($sformatf("v%0d_start", i), int'(start_addr),
                      vecs[i].exp_start);
                check($sformatf("v%0d_trig", i), int'(triggered), 1);
                check($sformatf("v%0d_busy", i), int'(busy), 0);
                check($sformatf("v%0d_first", i), first_addr, 0);
                if (vecs[i].exp_hit >= 0)
                    check($sformatf("v%0d_hit", i), hit_addr,
                          vecs[i].exp_hit);
            end else begin
                run(50 * (vecs[i].div + 1), vecs[i].div + 1, 1,
                    vecs[i].tog, -1, 8'h00);
                check($sformatf("v%0d_notrig", i), int'(triggered), 0);
                check($sformatf("v%0d_notdone", i), int'(done), 0);
                check($sformatf("v%0d_busy", i), int'(busy), 1);
                check($sformatf("v%0d_wrap", i), int'(nwr > 16), 1);
                abort = 1'b1;
                step();
                abort = 1'b0;
            end
            check($sformatf("v%0d_seq", i), seq_err, 0);
            check($sformatf("v%0d_gap", i), gap_err, 0);
        end

        configure(0, 3'd0, 8'h00, 8'h00, 0, 8'h33);
        do_arm();
        begin
            int c;
            c = 0;
            while (!(wr_en && wr_addr == 4'd5) && c < 40) begin
                step();
                c++;
            end
            check("abort_reach", int'(c < 40), 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_trig", int'(triggered), 0);
        check("abort_done", int'(done), 0);
        do_arm();
        run(40, 1, 0, 0, -1, 8'h00);
        check("rearm_first", first_addr, 0);
        check("rearm_nwr", nwr, 16);
        check("rearm_done", int'(done), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done_clr", int'(done), 0);
        check("abort_start_clr", int'(start_addr), 0);
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        step();
        check("arm_abort_busy", int'(busy), 0);
        check("arm_abort_wr", int'(wr_en), 0);

        configure(0, 3'd1, 8'hF0, 8'hA5, 0, 8'hB5);
        do_arm();
        run(40, 1, 0, 0, -1, 8'h00);
        check("lvl_b5_notrig", int'(triggered), 0);
        data_in = 8'hA0;
        watch = 8'hA0;
        run(60, 1, 0, 0, -1, 8'h00);
        check("lvl_a0_trig", int'(triggered), 1);
        check("lvl_a0_done", int'(done), 1);
        check("lvl_a0_start", int'(start_addr), hit_addr);
        abort = 1'b1;
        step();
        abort = 1'b0;

`ifdef LA_FORCE_TRIG_EN
        configure(3, 3'd1, 8'hFF, 8'h55, 0, 8'h00);
        do_arm();
        run(30, 4, 0, 0, -1, 8'h00);
        check("frc_pre_trig", int'(triggered), 0);
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        begin
            int nw;
            nw = 0;
            for (int c = 0; c < 10; c++) begin
                if (wr_en) nw++;
                if (triggered) break;
                step();
            end
            check("frc_trig", int'(triggered), 1);
            check("frc_one_tick", nw, 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        do_arm();
        run(30, 4, 0, 0, -1, 8'h00);
        check("frc_idle_ign", int'(triggered), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
Parametrised successor to the PMOD logic-analyser capture path. It samples N channels at a programmable rate and evaluates a masked trigger. Pre-trigger history is kept in a circular buffer, and a fixed number of post-trigger samples are captured. It drives the write port of an external dual-port capture RAM and reports where the window starts for readback. Everything runs on one clock domain, using a sample-enable tick rather than a derived clock.

Parameters:
CH_W, 8, number of sampled channels (data width).
ADDR_W, 17, capture RAM address width; DEPTH = 2**ADDR_W.
DIV_W, 16, width of the sample-rate divider setting.

Ports:
clk_50M  input  1  system clock
rst_n  input  1  asynchronous active-low reset
arm  input  1  single-cycle pulse; starts a capture from IDLE or DONE
abort  input  1  single-cycle pulse; returns to IDLE from any state
div_sel  input  DIV_W  sample period = div_sel+1 clocks
trig_mode  input  3  trigger type (see Behaviour)
trig_mask  input  CH_W  channels taking part in the trigger
trig_value  input  CH_W  level pattern for level mode
pretrig_len  input  ADDR_W  samples retained before the trigger
data_in  input  CH_W  asynchronous probe inputs
wr_addr  output  ADDR_W  RAM write address
wr_data  output  CH_W  RAM write data
wr_en  output  1  RAM write strobe, qualified by clk_50M
busy  output  1  high in PRE, WAIT_TRIG and POST
triggered  output  1  high from the trigger sample until the next arm or abort
done  output  1  high in DONE
start_addr  output  ADDR_W  address of the oldest sample in the window

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE.
- Input conditioning: data_in passes through a 2-flop synchroniser. Samples are taken from the synchronised value.
- Sample tick:
  - A divider counter counts 0..div_sel and emits tick when it wraps. div_sel=0 gives a tick every clock.
  - The counter clears on arm.
  - div_sel and the trig_* inputs are latched on arm and held stable for the whole capture.
- Write path: on every tick in PRE, WAIT_TRIG or POST:
  - wr_en=1 for exactly one clock.
  - wr_data is the synchronised sample.
  - wr_addr is the current pointer; the pointer then increments and wraps from DEPTH-1 to 0.
  - Write latency from the tick to wr_en is 1 clock.
- Pretrigger length: pretrig_len is latched on arm and clamped to DEPTH-1.
- Post count: POST_CNT = DEPTH - pretrig_len, which includes the trigger sample.
- State machine:
  - IDLE -> PRE on arm. The pointer resets to 0.
  - PRE writes samples; the trigger is ignored. After pretrig_len samples -> WAIT_TRIG. If pretrig_len=0, arm goes directly to WAIT_TRIG.
  - WAIT_TRIG keeps writing (circular overwrite). On the first tick whose sample satisfies the trigger:
    - trig_addr is set to the write address of that sample;
    - triggered=1;
    - -> POST.
  - POST writes until POST_CNT samples have been written, counting the trigger sample, then -> DONE.
  - DONE: no writes. start_addr = (trig_addr - pretrig_len) mod DEPTH. Returns to PRE on arm.
  - abort in any state -> IDLE: clears triggered and done, and drops any write pending for that cycle.
  - arm while busy is ignored.
  - If arm and abort arrive in the same cycle, abort wins.
- Trigger modes (tested only on masked channels; mask=0 makes every edge/level mode never fire):
  - 0: immediate; the first WAIT_TRIG sample fires.
  - 1: level; (s & mask) == (value & mask).
  - 2: rising; any masked channel goes 0->1 between consecutive samples.
  - 3: falling; any masked channel goes 1->0.
  - 4: either edge.
  - 5-7: reserved, behave as mode 0.
  - Edge detection compares against the previous tick's sample. The first sample after arm has no predecessor and produces no edge.
- start_addr is valid only while done=1 and reads 0 otherwise.

Optional Feature:
- Macro: LA_FORCE_TRIG_EN.
- With the macro defined: adds an input port force_trig (1 bit). A pulse while in WAIT_TRIG makes the next tick's sample the trigger sample, whatever trig_mode is. A pulse in any other state is ignored.
- Without the macro: the port is absent and only trig_mode can trigger.

Decomposition:
- Shared package la_pkg holds:
  - trig_mode constants TRIG_IMM, TRIG_LEVEL, TRIG_RISE, TRIG_FALL, TRIG_EDGE;
  - the state enum (IDLE, PRE, WAIT_TRIG, POST, DONE).
- Sub-module la_trig_detect takes the current sample, previous sample, mask, value and mode, and outputs a combinational hit. It holds the previous-sample register, enabled on tick.
- The divider, pointer, counters and FSM stay in la_capture_ctrl.

Test Plan:
- Immediate mode, DEPTH=16 (ADDR_W=4), div_sel=0, pretrig_len=0:
  - arm -> 16 consecutive wr_en pulses at addresses 0..15;
  - then done=1 and start_addr=0.
- Rate check, div_sel=3, mode 0 -> wr_en asserts exactly once every 4 clocks; each pulse's address is 1 above the previous pulse's address.
- Rising trigger, ADDR_W=4, pretrig_len=4, mask=8'h01:
  - ch0 rises on sample 10 -> trig_addr=10, POST writes 12 samples (addresses 10..5, wrapping), start_addr=6, and done asserts after the 22nd write.
- Level mode, mask=8'hF0, value=8'hA5:
  - input 8'hA0 fires; 8'hB5 does not.
  - mask=0 in mode 2 never fires, and the pointer keeps wrapping.
- Abort during POST -> wr_en drops the next clock; busy, triggered and done all read 0; a subsequent arm restarts at address 0.
- With LA_FORCE_TRIG_EN, mode 1 with a never-matching value:
  - force_trig in WAIT_TRIG -> triggered=1 on the next tick;
  - force_trig in IDLE -> no effect.
